// File: rtl/riscv_fetch_stage_if.sv
// rtl/riscv_fetch_stage_if.sv - fetch stage bus: imem port, control inputs, IF/ID outputs
// master: the fetch stage. Drives imem_addr, id_inst, id_pc, id_pc_plus4, id_valid, fetch_count.
// slave:  the surrounding core. Drives imem_inst, stall_f, flush_d, redirect_en, redirect_pc.
interface riscv_fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        stall_f;
    logic        flush_d;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, id_inst, id_pc, id_pc_plus4, id_valid, fetch_count,
        input  imem_inst, stall_f, flush_d, redirect_en, redirect_pc
    );

    modport slave (
        input  imem_addr, id_inst, id_pc, id_pc_plus4, id_valid, fetch_count,
        output imem_inst, stall_f, flush_d, redirect_en, redirect_pc
    );
endinterface

// File: rtl/riscv_fetch_stage.sv
// rtl/riscv_fetch_stage.sv - RV32I IF stage with PC register and IF/ID pipeline register
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - riscv_fetch_stage_if.master: imem address/instruction, stall/flush/redirect
//          controls, registered IF/ID outputs and the valid-fetch counter
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_fetch_stage_if.master    bus
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        ifid_kill;
    logic        ifid_load;

    logic [31:0] id_inst_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_pc_plus4_q;
    logic        id_valid_q;
    logic [31:0] fetch_count_q;

    assign pc_plus4 = pc + 32'd4;

    // imem_addr comes straight from the PC flop so no input can reach it combinationally.
    assign bus.imem_addr = pc;

    // Redirect wins over stall; target is word-aligned by dropping the low two bits.
    always_comb begin
        pc_next = pc_plus4;
        if (bus.redirect_en) begin
            pc_next = {bus.redirect_pc[31:2], 2'b00};
        end else if (bus.stall_f) begin
            pc_next = pc;
        end
    end

    // A redirect always squashes the wrong-path instruction currently being fetched.
    assign ifid_kill = bus.redirect_en | bus.flush_d;
    assign ifid_load = ~ifid_kill & ~bus.stall_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_inst_q     <= NOP_INST;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else if (ifid_kill) begin
            id_inst_q     <= NOP_INST;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            id_valid_q    <= 1'b0;
        end else if (ifid_load) begin
            id_inst_q     <= bus.imem_inst;
            id_pc_q       <= pc;
            id_pc_plus4_q <= pc_plus4;
            id_valid_q    <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.id_inst     = id_inst_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: doc/riscv_fetch_stage.md
Name: riscv_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the pipelined RV32I core.
- Owns the PC, drives the instruction-memory address, and registers the returned instruction with its PC and PC+4 for decode.
- Accepts a stall from the (future) hazard unit, a decode flush, and a branch/jump redirect from EX.
- Sits between the asynchronous-read imem and the decode stage inside top_riscv_pl.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_addr  output  32  instruction-memory address; equals current PC, combinational from the PC register.
- imem_inst  input  32  instruction word from imem; asynchronous read of imem_addr, valid in the same cycle.
- stall_f  input  1  hold PC and IF/ID contents.
- flush_d  input  1  replace IF/ID contents with a bubble.
- redirect_en  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  32  target PC when redirect_en=1.
- id_inst  output  32  registered instruction to decode.
- id_pc  output  32  registered PC of id_inst.
- id_pc_plus4  output  32  registered id_pc+4.
- id_valid  output  1  1 = id_inst is a real fetched instruction; 0 = bubble.
- fetch_count  output  32  count of instructions loaded into IF/ID with id_valid=1.

Behaviour:
- Clock and reset: single clock clk, rising edge. rst is asynchronous and active-high and takes effect immediately without a clock edge.
- Reset values:
  - PC = RESET_PC, so imem_addr = RESET_PC.
  - id_inst = NOP_INST; id_pc = 0; id_pc_plus4 = 0; id_valid = 0; fetch_count = 0.
- Reset asserted mid-operation discards all in-flight state. The first fetch after deassertion is RESET_PC.
- Next-PC priority, evaluated each rising edge:
  1. redirect_en: PC <= {redirect_pc[31:2], 2'b00}. The low two bits are forced to zero with no exception.
  2. stall_f: PC holds.
  3. Otherwise: PC <= PC + 4, 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- IF/ID register priority, evaluated each rising edge:
  1. redirect_en or flush_d: id_inst <= NOP_INST, id_valid <= 0, id_pc <= 0, id_pc_plus4 <= 0.
  2. stall_f: all IF/ID outputs hold.
  3. Otherwise: id_inst <= imem_inst, id_pc <= PC, id_pc_plus4 <= PC + 4, id_valid <= 1.
- Simultaneous events:
  - redirect_en overrides stall_f for both PC and IF/ID.
  - flush_d with stall_f, without redirect: IF/ID is flushed and the PC holds. The held instruction is re-fetched next cycle.
  - flush_d alone does not alter the PC.
- Latency: an instruction addressed in cycle N appears on id_* after the rising edge ending cycle N (one cycle).
- Redirect penalty: redirect asserted in cycle N puts the target on imem_addr in cycle N+1. The target instruction reaches id_* at the end of N+1. This gives exactly one bubble, plus any bubbles the EX stage adds via flush_d.
- fetch_count increments by 1 on every edge where IF/ID takes path 3. It wraps 32'hFFFF_FFFF to 0 and never decrements.
- No combinational path from any input to imem_addr. imem_addr depends only on the PC register.

Test Plan:
- Reset/sequential fetch: assert rst for 1 cycle, release, imem returns inst = addr^32'hA5A5_0000 -> imem_addr steps 0,4,8,C. The first valid id_pc=0 has id_inst=32'hA5A5_0000 and id_pc_plus4=4. After 4 loads, fetch_count=4.
- Stall: stall_f=1 for 2 cycles while PC=8 -> imem_addr stays 8. id_pc stays 4 with id_valid=1. fetch_count is frozen. After release, id_pc=8 next.
- Redirect: redirect_en=1 with redirect_pc=32'h0000_0102 while PC=10 -> next imem_addr=32'h100. The following id_* is NOP_INST with id_valid=0. Then id_pc=32'h100.
- Redirect with stall: redirect_en=1, stall_f=1, redirect_pc=32'h40 -> PC becomes 40 and IF/ID is flushed (id_valid=0). Stall has no effect.
- Flush with stall: flush_d=1, stall_f=1 at PC=20 -> id_inst=32'h0000_0013 and id_valid=0. imem_addr stays 20. With inputs then idle, id_pc=20 on the next edge.
- Wrap and async reset:
  - RESET_PC=32'hFFFF_FFF8 -> imem_addr goes FFFF_FFF8, FFFF_FFFC, then 0.
  - Pulsing rst between clock edges -> imem_addr=RESET_PC and id_valid=0 immediately, without waiting for a clock edge.
